// File: rtl/datapath_sequencer_if.sv
// datapath_sequencer_if: program load port, run control, datapath flags and datapath drive
interface datapath_sequencer_if #(
    parameter int AW = 4
);
    logic          load_valid;
    logic          load_ready;
    logic [AW-1:0] load_addr;
    logic [11:0]   load_data;
    logic [AW:0]   prog_len;
    logic          start;
    logic          zero;
    logic          overflow;
    logic [2:0]    alu_control;
    logic [1:0]    addr1;
    logic [1:0]    addr2;
    logic [1:0]    addr3;
    logic          wr;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   pc;

    modport master (
        output load_valid, load_addr, load_data, prog_len, start, zero, overflow,
        input  load_ready, alu_control, addr1, addr2, addr3, wr, busy, done, err, pc
    );

    modport slave (
        input  load_valid, load_addr, load_data, prog_len, start, zero, overflow,
        output load_ready, alu_control, addr1, addr2, addr3, wr, busy, done, err, pc
    );
endinterface

// File: rtl/datapath_sequencer.sv
// datapath_sequencer: micro-program sequencer driving a 4-register ALU datapath
module datapath_sequencer #(
    parameter int DEPTH       = 16,
    parameter int AW          = $clog2(DEPTH),
    parameter bit STOP_ON_OVF = 1'b1
) (
    input logic                 clk,
    input logic                 rst_n,
    datapath_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, FETCH, EXEC, DONE, ERR} state_t;

    state_t      state_q, state_d;
    logic [AW:0] pc_q, pc_d;
    logic [AW:0] len_q, len_d;
    logic [11:0] ir_q, ir_d;
    logic [8:0]  last_q, last_d;
    logic        err_q, err_d;
    logic [11:0] mem [DEPTH];
    logic        load_en;
    logic        skip;
    logic [AW:0] pc_next;

    assign load_en = bus.load_valid && bus.load_ready;
    assign skip    = ir_q[1] && bus.zero;
    assign pc_next = pc_q + (AW+1)'(1) + (AW+1)'(skip);

    // program store: written only while idle, contents survive reset
    always_ff @(posedge clk) if (load_en) mem[bus.load_addr] <= bus.load_data;

    // state register plus pc, latched length, instruction and last-driven fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            len_q   <= '0;
            ir_q    <= '0;
            last_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            ir_q    <= ir_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    // next state: start from idle, fetch, then execute with overflow > halt > step/skip priority
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        len_d   = len_q;
        ir_d    = ir_q;
        last_d  = last_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (bus.start) begin
                len_d   = bus.prog_len;
                err_d   = 1'b0;
                pc_d    = (bus.prog_len == '0) ? pc_q : '0;
                state_d = (bus.prog_len == '0) ? DONE : FETCH;
            end
            FETCH: begin
                ir_d    = mem[pc_q[AW-1:0]];
                state_d = EXEC;
            end
            EXEC: begin
                last_d = ir_q[11:3];
                if (bus.overflow && STOP_ON_OVF) begin
                    err_d   = 1'b1;
                    state_d = ERR;
                end else if (ir_q[0]) begin
                    state_d = DONE;
                end else begin
                    pc_d    = pc_next;
                    state_d = (pc_next >= len_q) ? DONE : FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // outputs: live instruction fields in EXEC, last executed fields elsewhere
    always_comb begin
        {bus.alu_control, bus.addr1, bus.addr2, bus.addr3} = (state_q == EXEC) ? ir_q[11:3] : last_q;
        bus.wr         = (state_q == EXEC) && ir_q[2];
        bus.busy       = (state_q == FETCH) || (state_q == EXEC);
        bus.done       = state_q == DONE;
        bus.err        = err_q;
        bus.pc         = pc_q;
        bus.load_ready = rst_n && (state_q == IDLE);
    end
endmodule

// File: doc/datapath_sequencer.md
# datapath_sequencer

Micro-program sequencer sitting directly upstream of the 4-register/ALU32 `datapath`. Holds a small loadable program of 12-bit micro-instructions. On `start` it steps through them, driving `ALUControl`, `addr1..3` and `wr` into the datapath one instruction at a time. It consumes the datapath's `Zero`/`Overflow` flags for skip-on-zero and overflow abort.

## Interface
- `DEPTH`, 16, program memory entries (power of two, ≥2)
- `AW`, 4, program address width, = log2(DEPTH)
- `STOP_ON_OVF`, 1, 1 = abort into error on `Overflow` during an executing instruction
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `load_valid`  in  1  program write request
- `load_ready`  out  1  program write accepted this cycle (high only in IDLE)
- `load_addr`  in  AW  program write address
- `load_data`  in  12  micro-instruction to store
- `prog_len`  in  AW+1  number of instructions to run, 0..DEPTH, sampled at `start`
- `start`  in  1  begin execution at pc=0 (honoured only in IDLE)
- `Zero`, `Overflow`  in  1 each  flags from datapath
- `ALUControl`  out  3  to datapath
- `addr1`, `addr2`, `addr3`  out  2 each  to datapath
- `wr`  out  1  datapath register write enable
- `busy`  out  1  high in FETCH/EXEC
- `done`  out  1  one-cycle pulse on normal completion
- `err`  out  1  sticky overflow-abort flag
- `pc`  out  AW+1  current program counter

## Operation
- Instruction fields: [11:9] ALUControl, [8:7] addr1, [6:5] addr2, [4:3] addr3, [2] we, [1] skz (skip next if Zero), [0] halt.
- States: IDLE, FETCH, EXEC, DONE, ERR.
- IDLE:
  - `load_ready`=1; `load_valid` writes `mem[load_addr]` <= `load_data` at the edge.
  - `start` latches `prog_len` and clears `err`. If `prog_len`==0 go to DONE, else pc<=0 and go to FETCH.
  - `load_valid` and `start` in the same cycle: the load completes, execution starts, and the newly loaded word is visible if fetched.
- FETCH: instruction register <= `mem[pc]`; go to EXEC.
- EXEC:
  - Outputs drive the instruction fields combinationally from the instruction register; `wr`=we for exactly this cycle.
  - `Zero`/`Overflow` are sampled at the end of the cycle, with priority:
    1. `Overflow` && STOP_ON_OVF: `err`<=1, go to ERR. The datapath write still lands at this edge.
    2. halt: go to DONE.
    3. Otherwise pc <= pc + 1 + (skz && Zero). If the new pc ≥ latched length go to DONE, else FETCH.
- pc is AW+1 bits wide, so a skip past the end (pc = len+1 ≤ DEPTH+1) cannot wrap. DEPTH+1 overflowing AW+1 bits is excluded by `prog_len` ≤ DEPTH.
- DONE: `done`=1 for one cycle, then IDLE.
- ERR: one cycle, then IDLE; `err` stays high until the next accepted `start`.
- `start` while busy is ignored. `load_valid` outside IDLE is ignored with no write.
- Memory contents are not reset; a program survives runs.

## Timing
- Reset (rst=0, asynchronous): state IDLE; pc, ALUControl, addr1..3 = 0; wr, busy, done, err = 0; `load_ready`=1 once released.
- Outside EXEC: wr=0, and ALUControl/addr outputs hold the last executed instruction's values (0 after reset).
- Latency: `start` accepted at edge 0 → FETCH in cycle 1 → EXEC in cycle 2 (wr high) → register write at edge 3.
- Each instruction costs 2 cycles; N instructions with no halt/skip give `done` in cycle 2N+1.
- Reset asserted mid-run: immediate return to reset values, wr drops asynchronously, and no further writes occur.

## Test plan
- Reset: hold rst=0 → all outputs 0, `load_ready`=1 after release; `start` with `prog_len`=0 → `done` pulse next cycle, wr never high.
- Single op: load 0x2F4 at addr 0 (R2←R1−R3, we=1), `prog_len`=1, `start` → cycle 2 shows ALUControl=001, addr1=1, addr2=3, addr3=2, wr=1; `done` in cycle 3.
- Skip: program [0x2F6 (skz), 0x000, 0x2F4] with Zero=1 during the first EXEC → pc sequence 0,2; instruction 1 is never driven; `done` after 4 busy cycles.
- Halt: [0x2F4, 0x2F5 (halt), 0x2F4], `prog_len`=3 → two EXECs only, `done` pulse, pc=1 at halt.
- Overflow: STOP_ON_OVF=1, Overflow=1 in the first EXEC → wr pulses once, ERR, `err`=1 held in IDLE; a new `start` clears it.
- Abuse: `start` during FETCH ignored; `load_valid` during EXEC leaves memory unchanged; rst pulled low during EXEC drops wr immediately.
